// File: rtl/mem_nport_pkg.sv
// Shared types and constants for the multi-port word memory.
package mem_nport_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam bit RDW_OLD = 1'b0;
    localparam bit RDW_NEW = 1'b1;

endpackage

// File: rtl/mem_nport_clear_fsm.sv
// Clear sequencer: walks every address once after reset or on request,
// holding busy high until the last word has been zeroed.
module mem_nport_clear_fsm
    import mem_nport_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              busy,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_s;
    logic              busy_r;

    // Next-state and clear counter logic
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            CLEAR: begin
                if (cnt_r == LAST_ADDR) begin
                    state_s = READY;
                    cnt_s   = '0;
                end else begin
                    cnt_s = cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            READY: begin
                if (clear_req) begin
                    state_s = CLEAR;
                    cnt_s   = '0;
                end else begin
                    state_s = READY;
                end
            end
            default: begin
                state_s = CLEAR;
                cnt_s   = '0;
            end
        endcase
    end

    // State, counter and busy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= CLEAR;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            busy_r  <= (state_s == CLEAR);
        end
    end

    assign busy     = busy_r;
    assign clr_en   = (state_r == CLEAR);
    assign clr_addr = cnt_r;

endmodule

// File: rtl/mem_nport.sv
// Multi-port byte-enabled word memory with registered reads, per-lane
// write priority (highest port index wins) and a built-in clear sequencer.
module mem_nport
    import mem_nport_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 9,
    parameter int NUM_RD  = 2,
    parameter int NUM_WR  = 2,
    parameter bit RDW_NEW = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_req,
    output logic                       busy,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_valid,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic [NUM_WR*(DATA_W/8)-1:0] wr_be
);

    localparam int  NB    = DATA_W / 8;
    localparam int  DEPTH = 1 << ADDR_W;
    localparam bit  FWD   = (RDW_NEW != mem_nport_pkg::RDW_OLD);

    logic [DATA_W-1:0]        mem [DEPTH];
    logic                     clr_en_s;
    logic [ADDR_W-1:0]        clr_addr_s;
    logic                     accept_s;
    logic [NUM_WR*NB-1:0]     win_s;
    logic [NUM_RD*DATA_W-1:0] rd_next_s;

    mem_nport_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .busy      (busy),
        .clr_en    (clr_en_s),
        .clr_addr  (clr_addr_s)
    );

    assign accept_s = ~busy & ~rst;

    // A lane of port p wins unless a higher port writes the same lane of the same address.
    for (genvar p = 0; p < NUM_WR; p++) begin : g_wr
        for (genvar b = 0; b < NB; b++) begin : g_lane
            logic win;
            // Per-lane write priority resolution
            always_comb begin
                win = wr_en[p] & wr_be[p*NB+b] & accept_s;
                for (int q = p + 1; q < NUM_WR; q++) begin
                    win = win & ~(wr_en[q] & wr_be[q*NB+b] &
                          (wr_addr[q*ADDR_W +: ADDR_W] == wr_addr[p*ADDR_W +: ADDR_W]));
                end
            end
            assign win_s[p*NB+b] = win;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        for (genvar b = 0; b < NB; b++) begin : g_lane
            logic [7:0] fwd;
            // Read byte selection with optional same-cycle write forwarding
            always_comb begin
                fwd = mem[rd_addr[k*ADDR_W +: ADDR_W]][b*8 +: 8];
                for (int p = 0; p < NUM_WR; p++) begin
                    fwd = (FWD && win_s[p*NB+b] &&
                           (wr_addr[p*ADDR_W +: ADDR_W] == rd_addr[k*ADDR_W +: ADDR_W]))
                          ? wr_data[p*DATA_W + b*8 +: 8] : fwd;
                end
            end
            assign rd_next_s[k*DATA_W + b*8 +: 8] = fwd;
        end
    end

    // Array update: the clear sequencer owns the array while clearing
    always_ff @(posedge clk) begin
        if (clr_en_s) begin
            mem[clr_addr_s] <= '0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                for (int b = 0; b < NB; b++) begin
                    if (win_s[p*NB+b]) begin
                        mem[wr_addr[p*ADDR_W +: ADDR_W]][b*8 +: 8] <= wr_data[p*DATA_W + b*8 +: 8];
                    end
                end
            end
        end
    end

    // Registered read data and valid
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= '0;
        end else begin
            for (int k = 0; k < NUM_RD; k++) begin
                rd_valid[k] <= rd_en[k] & accept_s;
                if (rd_en[k] & accept_s) begin
                    rd_data[k*DATA_W +: DATA_W] <= rd_next_s[k*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule
